cv32e40p_wide_reg_bridge: RTL
=============================

// Module: cv32e40p_wide_reg_bridge
// PURPOSE
//  Sits directly downstream of the core wrapper's wide register port (reg_rd/reg_wr/reg_wr_desp).
//  Serialises each 512-bit read/write into BEATS narrow transactions on a req/gnt/rvalid memory port.
//  Reassembles read beats into one 512-bit response.
//  Forwards descriptor writes to a valid/ready descriptor queue and acknowledges them back to the core.
// PARAMETERS
//  MEM_DW   128          memory data width in bits; must divide 512
//  BEATS    512/MEM_DW   beats per wide access (derived, not overridable)
//  MAX_OUT  4            max outstanding read beats (granted, rvalid pending), 1..BEATS
// PORTS
//  clk_i              in   1       clock
//  rst_ni             in   1       async active-low reset
//  reg_rd_i           in   1       1-cycle pulse: wide read request
//  reg_raddr_i        in   32      read byte address
//  reg_rdata_o        out  512     assembled read data
//  reg_rvalid_o       out  1       1-cycle pulse: reg_rdata_o valid
//  reg_wr_i           in   1       1-cycle pulse: wide memory write
//  reg_wr_desp_i      in   1       1-cycle pulse: descriptor write (uses reg_wdata_i; address ignored)
//  reg_waddr_i        in   32      write byte address
//  reg_wdata_i        in   512     write data
//  reg_rvalid_desp_o  out  1       1-cycle pulse: descriptor accepted by queue
//  mem_req_o          out  1       beat request
//  mem_gnt_i          in   1       beat grant
//  mem_we_o           out  1       beat is a write
//  mem_addr_o         out  32      beat byte address
//  mem_wdata_o        out  MEM_DW  beat write data
//  mem_rvalid_i       in   1       read beat response
//  mem_rdata_i        in   MEM_DW  read beat data
//  desp_valid_o       out  1       descriptor valid
//  desp_ready_i       in   1       descriptor queue ready
//  desp_data_o        out  512     descriptor payload
//  busy_o             out  1       bridge not in IDLE or request pending
//  err_o              out  1       sticky: dropped request or stray rvalid; cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0; reg_rdata_o = 0; FSM=IDLE; all counters 0.
//  Requests are sampled only in IDLE with no pending request.
//  A request pulse while busy_o=1 is dropped and sets err_o.
//  reg_wr_i and reg_wr_desp_i together: desp dropped, err_o set.
//  Request + address/data captured into internal registers on acceptance.
//  Same-cycle accept of write (or desp) and read: write/desp runs first; read is held pending and starts the cycle after the write completes.
//  Address: low 6 bits forced 0; beat i addr = base + i*(MEM_DW/8).
//  Beat i carries data[i*MEM_DW +: MEM_DW]; beats issued in ascending order.
//  States:
//   IDLE    -> WR (wr), DESP (desp), RD_REQ (rd only).
//   WR      mem_req_o=1, we=1, addr/wdata of beat cnt; hold until gnt.
//           On gnt of beat BEATS-1 -> RD_REQ if read pending, else IDLE.
//           No response to core.
//   DESP    desp_valid_o=1 with captured data until desp_ready_i.
//           Cycle after handshake: reg_rvalid_desp_o=1; -> RD_REQ if pending, else IDLE.
//   RD_REQ  mem_req_o=1, we=0 while issued<BEATS and outstanding<MAX_OUT; req held until gnt.
//           On last gnt -> RD_DRAIN.
//   RD_DRAIN wait until received==BEATS.
//           Cycle after last rvalid: reg_rvalid_o=1 and reg_rdata_o updated; -> IDLE.
//  rvalid handling: accepted in RD_REQ and RD_DRAIN; beat k written to slot k (in-order memory).
//   Outstanding = granted - received; gnt and rvalid in same cycle leave it unchanged.
//   rvalid in any other state: ignored, sets err_o.
//  Latency: min read = BEATS+2 cycles from reg_rd_i to reg_rvalid_o (gnt/rvalid zero-wait, 1-cycle rvalid);
//           write = BEATS+1 cycles to IDLE.
//  reg_rdata_o holds its value until the next read completes.
//  mem_* outputs change only on gnt or state change (AMBA-like stable request).
//  Reset mid-operation: immediate abort to IDLE; late rvalids after reset set err_o only.
// TESTING
//  1 zero-wait read at 0x1000_0047: beats at 0x...040/050/060/070; reg_rvalid_o at cycle 6; data = {b3,b2,b1,b0}.
//  2 write 0x2000_0000, gnt low 3 cycles per beat: addr/wdata stable while waiting; IDLE after 4 gnts; no reg_rvalid_o.
//  3 desp write with desp_ready_i low 5 cycles: desp_valid_o held 6 cycles; reg_rvalid_desp_o 1 pulse; no mem_req_o.
//  4 reg_wr_i+reg_rd_i same cycle: 4 write beats, then 4 read beats; exactly one reg_rvalid_o; err_o=0.
//  5 MAX_OUT=2, rvalid delay 4: never >2 outstanding; read completes correctly; reg_rd_i pulse while busy -> err_o=1, ignored.
//  6 rst_ni low after 2 read grants; rvalids arrive after release: FSM IDLE, reg_rvalid_o stays 0, err_o=1.

Source files
------------

// File: rtl/cv32e40p_wide_reg_bridge.sv
// cv32e40p_wide_reg_bridge: serialises 512-bit register-port reads/writes into MEM_DW beats
// on a req/gnt/rvalid port and forwards descriptor writes to a valid/ready queue.
module cv32e40p_wide_reg_bridge #(
  parameter int MEM_DW  = 128,
  parameter int MAX_OUT = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              reg_rd_i,
  input  logic [31:0]       reg_raddr_i,
  output logic [511:0]      reg_rdata_o,
  output logic              reg_rvalid_o,
  input  logic              reg_wr_i,
  input  logic              reg_wr_desp_i,
  input  logic [31:0]       reg_waddr_i,
  input  logic [511:0]      reg_wdata_i,
  output logic              reg_rvalid_desp_o,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [MEM_DW-1:0] mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [MEM_DW-1:0] mem_rdata_i,
  output logic              desp_valid_o,
  input  logic              desp_ready_i,
  output logic [511:0]      desp_data_o,
  output logic              busy_o,
  output logic              err_o
);
  localparam int BEATS = 512 / MEM_DW;
  localparam int CW    = $clog2(BEATS + 1);
  localparam int IW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [31:0] BSTEP = 32'(MEM_DW / 8);

  typedef enum logic [2:0] {IDLE, WR, DESP, RD_REQ, RD_DRAIN} state_e;

  state_e                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d, rcv_q, rcv_d, out_w;
  logic [31:0]                  waddr_q, waddr_d, raddr_q, raddr_d, addr_off;
  logic [BEATS-1:0][MEM_DW-1:0] wdata_q, wdata_d, buf_q, buf_d;
  logic [511:0]                 rdata_q, rdata_d;
  logic                         rd_pend_q, rd_pend_d, rvalid_q, rvalid_d;
  logic                         dack_q, dack_d, err_q, err_d;
  logic                         busy, wr_go, desp_go, rd_go, drop, rd_active, rd_issue;
  logic                         rv_ok, gnt_fire, beat_last, rcv_last;

  // Write/descriptor wins a same-cycle collision; the read waits in rd_pend_q.
  always_comb begin
    busy      = (state_q != IDLE) || rd_pend_q;
    wr_go     = !busy && reg_wr_i;
    desp_go   = !busy && reg_wr_desp_i && !reg_wr_i;
    rd_go     = !busy && reg_rd_i;
    drop      = busy ? (reg_wr_i || reg_wr_desp_i || reg_rd_i) : (reg_wr_i && reg_wr_desp_i);
    out_w     = cnt_q - rcv_q;
    rd_active = (state_q == RD_REQ) || (state_q == RD_DRAIN);
    rd_issue  = (state_q == RD_REQ) && (cnt_q < CW'(BEATS)) && (out_w < CW'(MAX_OUT));
    rv_ok     = mem_rvalid_i && rd_active && (out_w != '0);
    gnt_fire  = mem_gnt_i && ((state_q == WR) || rd_issue);
    beat_last = cnt_q == CW'(BEATS - 1);
    rcv_last  = rv_ok && (rcv_q == CW'(BEATS - 1));
    addr_off  = 32'(cnt_q) * BSTEP;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = wr_go ? WR : desp_go ? DESP : rd_go ? RD_REQ : IDLE;
      WR:       if (gnt_fire && beat_last) state_d = rd_pend_q ? RD_REQ : IDLE;
      DESP:     if (desp_ready_i) state_d = rd_pend_q ? RD_REQ : IDLE;
      RD_REQ:   if (gnt_fire && beat_last) state_d = RD_DRAIN;
      RD_DRAIN: if (rcv_last) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Responses are in order, so the receive count doubles as the slot index.
  always_comb begin
    cnt_d     = rcv_last ? '0 : gnt_fire ? (((state_q == WR) && beat_last) ? '0 : cnt_q + CW'(1)) : cnt_q;
    rcv_d     = rcv_last ? '0 : rv_ok ? rcv_q + CW'(1) : rcv_q;
    rd_pend_d = ((state_d == RD_REQ) && (state_q != RD_REQ)) ? 1'b0 : rd_pend_q || ((wr_go || desp_go) && reg_rd_i);
    raddr_d   = rd_go ? (reg_raddr_i & ~32'h3f) : raddr_q;
    waddr_d   = wr_go ? (reg_waddr_i & ~32'h3f) : waddr_q;
    wdata_d   = (wr_go || desp_go) ? reg_wdata_i : wdata_q;
    buf_d     = buf_q;
    if (rv_ok) buf_d[rcv_q[IW-1:0]] = mem_rdata_i;
    rdata_d   = rcv_last ? buf_d : rdata_q;
    rvalid_d  = rcv_last;
    dack_d    = (state_q == DESP) && desp_ready_i;
    err_d     = err_q || drop || (mem_rvalid_i && !rv_ok);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      rcv_q     <= '0;
      rd_pend_q <= 1'b0;
      raddr_q   <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      buf_q     <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      dack_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rcv_q     <= rcv_d;
      rd_pend_q <= rd_pend_d;
      raddr_q   <= raddr_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      buf_q     <= buf_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      dack_q    <= dack_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    mem_req_o         = (state_q == WR) || rd_issue;
    mem_we_o          = state_q == WR;
    mem_addr_o        = (state_q == WR) ? waddr_q + addr_off : (state_q == RD_REQ) ? raddr_q + addr_off : '0;
    mem_wdata_o       = (state_q == WR) ? wdata_q[cnt_q[IW-1:0]] : '0;
    desp_valid_o      = state_q == DESP;
    desp_data_o       = wdata_q;
    reg_rdata_o       = rdata_q;
    reg_rvalid_o      = rvalid_q;
    reg_rvalid_desp_o = dack_q;
    busy_o            = busy;
    err_o             = err_q;
  end
endmodule
